// File: rtl/mul_xxbit_booth_r4.sv
// mul_xxbit_booth_r4
// Iterative radix-4 Booth multiplier: DATA_WIDTH x DATA_WIDTH -> 2*DATA_WIDTH.
// Signed or unsigned operation is chosen per operation by i_sgn. The block retires
// two multiplier bits per cycle and finishes in DATA_WIDTH/2+1 cycles.
//
// Ports
//   i_clk    clock, rising edge
//   i_rst    synchronous reset, active high
//   i_vld    operands valid
//   o_rdy    operands can be accepted this cycle
//   i_sgn    1: two's complement operands, 0: unsigned operands
//   i_num_a  multiplicand
//   i_num_b  multiplier
//   i_kill   abort the operation in flight (ignored while idle)
//   o_vld    product valid
//   i_rdy    consumer accepts the product
//   o_res    product, held until the next completion, kill or reset
//   o_busy   iteration in progress
module mul_xxbit_booth_r4 #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_vld,
  output logic                      o_rdy,
  input  logic                      i_sgn,
  input  logic [DATA_WIDTH-1:0]     i_num_a,
  input  logic [DATA_WIDTH-1:0]     i_num_b,
  input  logic                      i_kill,
  output logic                      o_vld,
  input  logic                      i_rdy,
  output logic [2*DATA_WIDTH-1:0]   o_res,
  output logic                      o_busy
);

  localparam int unsigned EW   = DATA_WIDTH + 2;       // extended operand width
  localparam int unsigned AW   = 2 * DATA_WIDTH + 4;   // accumulator width
  localparam int unsigned N    = DATA_WIDTH / 2 + 1;   // iterations
  localparam int unsigned CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((DATA_WIDTH % 2) != 0 || DATA_WIDTH < 4) begin : g_bad_width
    $error("mul_xxbit_booth_r4: DATA_WIDTH must be even and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] cnt_q;
  logic [AW-1:0] acc_q;
  logic [AW-1:0] mcand_q;   // multiplicand, pre-shifted to weight 4^cnt
  logic [EW:0]   mplr_q;    // {multiplier, b[-1]}, shifted right 2 per cycle
  logic [AW-1:0] pp;
  logic [AW-1:0] acc_nxt;
  logic [EW-1:0] a_ext;
  logic [EW-1:0] b_ext;
  logic          accept;
  logic          last;

  // Extension to DW+2 bits makes every operand a non-negative or negative
  // two's complement value that the signed Booth recoding handles exactly.
  assign a_ext = {{2{i_sgn & i_num_a[DATA_WIDTH-1]}}, i_num_a};
  assign b_ext = {{2{i_sgn & i_num_b[DATA_WIDTH-1]}}, i_num_b};

  assign o_vld  = (state_q == DONE);
  assign o_busy = (state_q == CALC);

  // In DONE, a kill takes priority over a same-cycle handshake, so new
  // operands are not offered acceptance then.
  always_comb begin
    o_rdy = 1'b0;
    case (state_q)
      IDLE:    o_rdy = 1'b1;
      DONE:    o_rdy = i_rdy & ~i_kill;
      default: o_rdy = 1'b0;
    endcase
  end

  assign accept = i_vld & o_rdy;
  assign last   = (cnt_q == LAST);

  always_comb begin
    pp = '0;
    case (mplr_q[2:0])
      3'b001, 3'b010: pp = mcand_q;
      3'b011:         pp = mcand_q << 1;
      3'b100:         pp = -(mcand_q << 1);
      3'b101, 3'b110: pp = -mcand_q;
      default:        pp = '0;
    endcase
  end

  assign acc_nxt = acc_q + pp;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = CALC;
      end
      CALC: begin
        if (i_kill)    state_d = IDLE;
        else if (last) state_d = DONE;
      end
      DONE: begin
        if (i_kill)      state_d = IDLE;
        else if (i_rdy)  state_d = accept ? CALC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      o_res   <= '0;
    end else if (i_kill && state_q != IDLE) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      o_res   <= '0;
    end else if (accept) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= {{(AW-EW){a_ext[EW-1]}}, a_ext};
      mplr_q  <= {b_ext, 1'b0};
    end else if (state_q == CALC) begin
      cnt_q   <= cnt_q + 1'b1;
      acc_q   <= acc_nxt;
      mcand_q <= mcand_q << 2;
      mplr_q  <= {2'b00, mplr_q[EW:2]};
      if (last) o_res <= acc_nxt[2*DATA_WIDTH-1:0];
    end
  end

endmodule
